// File: rtl/pipe_stage_skid_if.sv
// pipe_stage_skid_if: valid/ready bus carrying an opaque payload and a control field
interface pipe_stage_skid_if #(
   parameter int DATA_W = 101,
   parameter int CTRL_W = 8
);
   logic              valid;
   logic              ready;
   logic [DATA_W-1:0] data;
   logic [CTRL_W-1:0] ctrl;
   modport master (output valid, data, ctrl, input ready);
   modport slave (input valid, data, ctrl, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: pipeline stage register with a two-entry skid buffer, flush-to-bubble and a saturating stall counter
module pipe_stage_skid #(
   parameter int DATA_W = 101,
   parameter int CTRL_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   pipe_stage_skid_if.slave  up,
   pipe_stage_skid_if.master dn,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt
);
   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
   state_t            state;
   logic              in_ready;
   logic              out_valid;
   logic [DATA_W-1:0] main_data;
   logic [DATA_W-1:0] skid_data;
   logic [CTRL_W-1:0] main_ctrl;
   logic [CTRL_W-1:0] skid_ctrl;
   logic              accept;
   logic              pop;
   assign accept    = up.valid & in_ready;
   assign pop       = out_valid & dn.ready;
   assign up.ready  = in_ready;
   assign dn.valid  = out_valid;
   assign dn.data   = main_data;
   assign dn.ctrl   = main_ctrl;
   assign occupancy = state;
   // occupancy FSM: main register feeds the outputs, skid catches the one entry accepted after back-pressure
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state     <= EMPTY;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         main_data <= '0;
         main_ctrl <= '0;
         skid_data <= '0;
         skid_ctrl <= '0;
      end else if (flush) begin
         state     <= EMPTY;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         main_ctrl <= '0;
      end else begin
         case (state)
            EMPTY:
               if (accept) begin
                  state     <= ONE;
                  out_valid <= 1'b1;
                  main_data <= up.data;
                  main_ctrl <= up.ctrl;
               end
            ONE:
               if (accept && pop) begin
                  main_data <= up.data;
                  main_ctrl <= up.ctrl;
               end else if (accept) begin
                  state     <= TWO;
                  in_ready  <= 1'b0;
                  skid_data <= up.data;
                  skid_ctrl <= up.ctrl;
               end else if (pop) begin
                  state     <= EMPTY;
                  out_valid <= 1'b0;
                  main_ctrl <= '0;
               end
            TWO:
               if (pop) begin
                  state     <= ONE;
                  in_ready  <= 1'b1;
                  main_data <= skid_data;
                  main_ctrl <= skid_ctrl;
               end
            default: begin
               state     <= EMPTY;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               main_ctrl <= '0;
            end
         endcase
      end
   // count cycles where a live head entry is refused downstream, holding at the maximum
   always_ff @(posedge clk or negedge reset)
      if (!reset)
         stall_cnt <= '0;
      else if (out_valid && !dn.ready && !(&stall_cnt))
         stall_cnt <= stall_cnt + 1'b1;
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed and random checks of pipe_stage_skid against a queue-based reference model
module tb_pipe_stage_skid;
   localparam int DATA_W = 16;
   localparam int CTRL_W = 8;
   localparam int CNT_W  = 3;
   localparam int SMAX   = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             flush = 1'b0;
   logic [1:0]       occupancy;
   logic [CNT_W-1:0] stall_cnt;

   pipe_stage_skid_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) up_if ();
   pipe_stage_skid_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dn_if ();

   pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .up        (up_if.slave),
      .dn        (dn_if.master),
      .occupancy (occupancy),
      .stall_cnt (stall_cnt)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          passed = 0;
   int          fails = 0;
   logic [23:0] q[$];
   int          m_stall = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      logic [23:0] head;
      head = (q.size() > 0) ? q[0] : 24'h0;
      chk("occupancy", 32'(occupancy), 32'(q.size()));
      chk("in_ready", 32'(up_if.ready), 32'(q.size() < 2));
      chk("out_valid", 32'(dn_if.valid), 32'(q.size() > 0));
      chk("out_ctrl", 32'(dn_if.ctrl), 32'(head[23:16]));
      chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
      if (q.size() > 0) chk("out_data", 32'(dn_if.data), 32'(head[15:0]));
   endtask

   task automatic check_reset();
      chk("rst_out_valid", 32'(dn_if.valid), 32'd0);
      chk("rst_out_ctrl", 32'(dn_if.ctrl), 32'd0);
      chk("rst_out_data", 32'(dn_if.data), 32'd0);
      chk("rst_occupancy", 32'(occupancy), 32'd0);
      chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      chk("rst_in_ready", 32'(up_if.ready), 32'd1);
   endtask

   task automatic cyc(input logic iv, input logic [15:0] d, input logic [7:0] c, input logic ordy, input logic fl);
      bit acc;
      bit pp;
      up_if.valid = iv;
      up_if.data  = d;
      up_if.ctrl  = c;
      dn_if.ready = ordy;
      flush       = fl;
      @(posedge clk);
      acc = iv && (q.size() < 2);
      pp  = (q.size() > 0) && ordy;
      if (q.size() > 0 && !ordy && m_stall < SMAX) m_stall++;
      if (fl) q.delete();
      else begin
         if (pp) void'(q.pop_front());
         if (acc) q.push_back({c, d});
      end
      #1 check_model();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1);
   end

   initial begin
      up_if.valid = 1'b0;
      up_if.data  = '0;
      up_if.ctrl  = '0;
      dn_if.ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 check_reset();
      reset = 1'b1;

      for (int i = 1; i <= 8; i++) cyc(1'b1, 16'(i), 8'hA5, 1'b1, 1'b0);
      chk("stream_last", 32'(dn_if.data), 32'd8);
      cyc(1'b0, 16'h0, 8'h0, 1'b1, 1'b0);

      cyc(1'b1, 16'd1, 8'h01, 1'b1, 1'b0);
      cyc(1'b1, 16'd2, 8'h02, 1'b0, 1'b0);
      chk("bp_occ2", 32'(occupancy), 32'd2);
      cyc(1'b1, 16'd3, 8'h03, 1'b0, 1'b0);
      cyc(1'b1, 16'd3, 8'h03, 1'b0, 1'b0);
      chk("bp_stall", 32'(stall_cnt), 32'd3);
      chk("bp_in_ready", 32'(up_if.ready), 32'd0);
      cyc(1'b1, 16'd3, 8'h03, 1'b1, 1'b0);
      chk("bp_head2", 32'(dn_if.data), 32'd2);
      cyc(1'b1, 16'd3, 8'h03, 1'b1, 1'b0);
      chk("bp_head3", 32'(dn_if.data), 32'd3);
      cyc(1'b0, 16'h0, 8'h0, 1'b1, 1'b0);

      cyc(1'b1, 16'h10, 8'h5A, 1'b0, 1'b0);
      cyc(1'b1, 16'h11, 8'h5B, 1'b0, 1'b0);
      cyc(1'b1, 16'h12, 8'h5C, 1'b0, 1'b1);
      chk("flush_valid", 32'(dn_if.valid), 32'd0);
      chk("flush_ctrl", 32'(dn_if.ctrl), 32'd0);
      chk("flush_occ", 32'(occupancy), 32'd0);
      chk("flush_in_ready", 32'(up_if.ready), 32'd1);
      repeat (3) cyc(1'b0, 16'h0, 8'h0, 1'b1, 1'b0);

      cyc(1'b1, 16'h30, 8'h30, 1'b0, 1'b0);
      cyc(1'b1, 16'h31, 8'h31, 1'b0, 1'b0);
      cyc(1'b1, 16'h32, 8'h32, 1'b1, 1'b0);
      chk("two_pop_head", 32'(dn_if.data), 32'h31);
      chk("two_pop_occ", 32'(occupancy), 32'd1);
      cyc(1'b1, 16'h32, 8'h32, 1'b0, 1'b0);
      chk("two_pop_c_acc", 32'(occupancy), 32'd2);
      repeat (3) cyc(1'b0, 16'h0, 8'h0, 1'b1, 1'b0);

      cyc(1'b1, 16'h50, 8'h50, 1'b0, 1'b0);
      cyc(1'b1, 16'h51, 8'h51, 1'b0, 1'b0);
      #2 reset = 1'b0;
      #1 check_reset();
      q.delete();
      m_stall = 0;
      @(posedge clk);
      #1 check_reset();
      #2 reset = 1'b1;
      cyc(1'b1, 16'h20, 8'h20, 1'b1, 1'b0);
      chk("rst_first_valid", 32'(dn_if.valid), 32'd1);
      chk("rst_first_data", 32'(dn_if.data), 32'h20);
      cyc(1'b0, 16'h0, 8'h0, 1'b1, 1'b0);

      cyc(1'b1, 16'h40, 8'h40, 1'b1, 1'b0);
      repeat (10) cyc(1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
      chk("sat_stall", 32'(stall_cnt), 32'(SMAX));
      cyc(1'b0, 16'h0, 8'h0, 1'b1, 1'b0);

      for (int i = 0; i < 400; i++)
         cyc(1'($urandom_range(0, 3) != 0), 16'($urandom), 8'($urandom),
             1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
